// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - ID/EX operand stage bus: decode inputs, hazard inputs, EX outputs
// Ports (signals):
//   id_*            decoded instruction fields presented by the decode stage
//   flush           squash the decode instruction (taken branch)
//   exmem_*/memwb_* destination info of the instructions now in MEM and WB
//   stall           hold PC and IF/ID
//   ex_*            registered EX-stage operands, control and forwarding selects
// Modports: master drives the decode/hazard side, slave is the operand stage.
interface ex_operand_stage_if #(
    parameter int WIDTH = 64,
    parameter int REGW  = 5
);
    logic             id_valid;
    logic [REGW-1:0]  id_rn;
    logic [REGW-1:0]  id_rm;
    logic [REGW-1:0]  id_rd;
    logic             id_use_rn;
    logic             id_use_rm;
    logic             id_use_imm;
    logic [WIDTH-1:0] id_rn_data;
    logic [WIDTH-1:0] id_rm_data;
    logic [WIDTH-1:0] id_imm;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic [REGW-1:0]  exmem_rd;
    logic             exmem_reg_write;
    logic [REGW-1:0]  memwb_rd;
    logic             memwb_reg_write;
    logic [WIDTH-1:0] memwb_wdata;
    logic             stall;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_rn_data;
    logic [WIDTH-1:0] ex_rm_data;
    logic [WIDTH-1:0] ex_imm;
    logic [REGW-1:0]  ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [1:0]       ex_a_sel;
    logic [1:0]       ex_b_sel;

    modport master (
        output id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_imm,
               id_rn_data, id_rm_data, id_imm, id_reg_write, id_mem_read, flush,
               exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write, memwb_wdata,
        input  stall, ex_valid, ex_rn_data, ex_rm_data, ex_imm, ex_rd,
               ex_reg_write, ex_mem_read, ex_a_sel, ex_b_sel
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_imm,
               id_rn_data, id_rm_data, id_imm, id_reg_write, id_mem_read, flush,
               exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write, memwb_wdata,
        output stall, ex_valid, ex_rn_data, ex_rm_data, ex_imm, ex_rd,
               ex_reg_write, ex_mem_read, ex_a_sel, ex_b_sel
    );
endinterface

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with forwarding selects and load-use stall
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    ex_operand_stage_if.slave: decode fields in, stall and EX-stage registers out
// Select encoding: 00 register value, 01 EX/MEM result, 10 MEM/WB data, 11 immediate (B only).
module ex_operand_stage #(
    parameter int WIDTH    = 64,
    parameter int REGW     = 5,
    parameter int ZERO_REG = 31
) (
    input  logic               clk,
    input  logic               reset,
    ex_operand_stage_if.slave  bus
);
    localparam logic [REGW-1:0] ZR = REGW'(ZERO_REG);

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    logic             ex_valid_q;
    logic [WIDTH-1:0] ex_rn_data_q, ex_rn_data_d;
    logic [WIDTH-1:0] ex_rm_data_q, ex_rm_data_d;
    logic [WIDTH-1:0] ex_imm_q;
    logic [REGW-1:0]  ex_rd_q;
    logic             ex_reg_write_q;
    logic             ex_mem_read_q;
    logic [1:0]       ex_a_sel_q, ex_a_sel_d;
    logic [1:0]       ex_b_sel_q, ex_b_sel_d;

    logic ex_prod;   // current EX instruction will produce a forwardable result
    logic mem_prod;  // current MEM instruction will produce a forwardable result
    logic wb_prod;   // WB is writing a real register this cycle
    logic stall_c;

    // A producer writing ZERO_REG is excluded here, which also keeps ZERO_REG
    // sources from ever matching.
    assign ex_prod  = ex_valid_q & ex_reg_write_q & (ex_rd_q != ZR);
    assign mem_prod = bus.exmem_reg_write & (bus.exmem_rd != ZR);
    assign wb_prod  = bus.memwb_reg_write & (bus.memwb_rd != ZR);

    assign stall_c = bus.id_valid & ex_prod & ex_mem_read_q
                   & ((bus.id_use_rn & (ex_rd_q == bus.id_rn))
                    | (bus.id_use_rm & ~bus.id_use_imm & (ex_rd_q == bus.id_rm)))
                   & ~bus.flush & ~reset;

    always_comb begin
        ex_a_sel_d   = SEL_REG;
        ex_b_sel_d   = SEL_REG;
        ex_rn_data_d = bus.id_rn_data;
        ex_rm_data_d = bus.id_rm_data;

        // Newer producer (EX) is checked first so it wins over MEM.
        if (bus.id_use_rn) begin
            if (ex_prod && ex_rd_q == bus.id_rn)
                ex_a_sel_d = SEL_EXM;
            else if (mem_prod && bus.exmem_rd == bus.id_rn)
                ex_a_sel_d = SEL_MWB;
        end

        if (bus.id_use_imm)
            ex_b_sel_d = SEL_IMM;
        else if (bus.id_use_rm) begin
            if (ex_prod && ex_rd_q == bus.id_rm)
                ex_b_sel_d = SEL_EXM;
            else if (mem_prod && bus.exmem_rd == bus.id_rm)
                ex_b_sel_d = SEL_MWB;
        end

        // The register file is read before WB writes it this cycle, so the
        // value being written is captured instead.
        if (wb_prod && bus.memwb_rd == bus.id_rn)
            ex_rn_data_d = bus.memwb_wdata;
        if (wb_prod && bus.memwb_rd == bus.id_rm)
            ex_rm_data_d = bus.memwb_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_rn_data_q   <= '0;
            ex_rm_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_a_sel_q     <= SEL_REG;
            ex_b_sel_q     <= SEL_REG;
        end else if (bus.flush || stall_c) begin
            // Bubble: data registers are don't-care and left untouched.
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_a_sel_q     <= SEL_REG;
            ex_b_sel_q     <= SEL_REG;
        end else begin
            ex_valid_q     <= bus.id_valid;
            ex_rn_data_q   <= ex_rn_data_d;
            ex_rm_data_q   <= ex_rm_data_d;
            ex_imm_q       <= bus.id_imm;
            ex_rd_q        <= bus.id_rd;
            ex_reg_write_q <= bus.id_valid & bus.id_reg_write;
            ex_mem_read_q  <= bus.id_valid & bus.id_mem_read;
            ex_a_sel_q     <= ex_a_sel_d;
            ex_b_sel_q     <= ex_b_sel_d;
        end
    end

    assign bus.stall        = stall_c;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_rn_data   = ex_rn_data_q;
    assign bus.ex_rm_data   = ex_rm_data_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_reg_write = ex_reg_write_q;
    assign bus.ex_mem_read  = ex_mem_read_q;
    assign bus.ex_a_sel     = ex_a_sel_q;
    assign bus.ex_b_sel     = ex_b_sel_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    ex_operand_stage_if #(.WIDTH(64), .REGW(5)) bus ();

    ex_operand_stage #(.WIDTH(64), .REGW(5), .ZERO_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic urn, input logic urm,
                          input logic uimm, input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_rn        = rn;
        bus.id_rm        = rm;
        bus.id_rd        = rd;
        bus.id_use_rn    = urn;
        bus.id_use_rm    = urm;
        bus.id_use_imm   = uimm;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_rn_data   = 64'h0;
        bus.id_rm_data   = 64'h0;
        bus.id_imm       = 64'h0;
    endtask

    task automatic set_exmem(input logic [4:0] rd, input logic w);
        bus.exmem_rd        = rd;
        bus.exmem_reg_write = w;
    endtask

    task automatic set_memwb(input logic [4:0] rd, input logic w, input logic [63:0] d);
        bus.memwb_rd        = rd;
        bus.memwb_reg_write = w;
        bus.memwb_wdata     = d;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.flush = 1'b0;
        set_exmem(5'd0, 1'b0);
        set_memwb(5'd0, 1'b0, 64'h0);
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.id_rn_data = 64'h55;

        // Reset held two cycles with a valid instruction presented
        step();
        step();
        check("rst_valid", 64'(bus.ex_valid), 64'd0);
        check("rst_asel",  64'(bus.ex_a_sel), 64'd0);
        check("rst_bsel",  64'(bus.ex_b_sel), 64'd0);
        check("rst_stall", 64'(bus.stall),    64'd0);
        check("rst_rd",    64'(bus.ex_rd),    64'd0);
        check("rst_rn_data", bus.ex_rn_data,  64'd0);
        reset = 1'b0;

        // EX forward: ADD X1 then a reader of X1
        set_id(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("add_valid", 64'(bus.ex_valid),     64'd1);
        check("add_rd",    64'(bus.ex_rd),        64'd1);
        check("add_rw",    64'(bus.ex_reg_write), 64'd1);
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.id_rm_data = 64'h1111;
        step();
        check("exfwd_asel", 64'(bus.ex_a_sel), 64'd1);
        check("exfwd_bsel", 64'(bus.ex_b_sel), 64'd0);
        check("exfwd_rm_data", bus.ex_rm_data, 64'h1111);

        // MEM forward on A, EX forward on B
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        set_exmem(5'd3, 1'b1);
        set_id(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("memfwd_asel", 64'(bus.ex_a_sel), 64'd2);
        check("memfwd_bsel", 64'(bus.ex_b_sel), 64'd1);

        // Both EX and MEM write X3: newer (EX) wins
        set_exmem(5'd0, 1'b0);
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        set_exmem(5'd3, 1'b1);
        set_id(1'b1, 5'd3, 5'd0, 5'd20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("prio_asel", 64'(bus.ex_a_sel), 64'd1);

        // Load-use on Rm: one stall, bubble, then capture with MEM/WB select
        set_exmem(5'd0, 1'b0);
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check("ld_mem_read", 64'(bus.ex_mem_read), 64'd1);
        set_id(1'b1, 5'd6, 5'd5, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("lu_stall", 64'(bus.stall), 64'd1);
        step();
        check("lu_bubble_valid", 64'(bus.ex_valid),     64'd0);
        check("lu_bubble_rw",    64'(bus.ex_reg_write), 64'd0);
        check("lu_bubble_bsel",  64'(bus.ex_b_sel),     64'd0);
        set_exmem(5'd5, 1'b1);
        #1;
        check("lu_stall_drop", 64'(bus.stall), 64'd0);
        step();
        check("lu_cap_valid", 64'(bus.ex_valid), 64'd1);
        check("lu_cap_bsel",  64'(bus.ex_b_sel), 64'd2);
        check("lu_cap_asel",  64'(bus.ex_a_sel), 64'd0);
        check("lu_cap_rd",    64'(bus.ex_rd),    64'd11);

        // ZERO_REG load never stalls or forwards
        set_exmem(5'd0, 1'b0);
        set_id(1'b1, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd31, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("zr_stall", 64'(bus.stall), 64'd0);
        step();
        check("zr_asel",  64'(bus.ex_a_sel), 64'd0);
        check("zr_valid", 64'(bus.ex_valid), 64'd1);

        // Immediate overrides an Rm match
        set_id(1'b1, 5'd0, 5'd12, 5'd13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.id_imm = 64'h1234;
        step();
        check("imm_bsel", 64'(bus.ex_b_sel), 64'd3);
        check("imm_asel", 64'(bus.ex_a_sel), 64'd0);
        check("imm_val",  bus.ex_imm,        64'h1234);

        // WB write-through into captured Rn data
        set_memwb(5'd7, 1'b1, 64'hDEAD);
        set_id(1'b1, 5'd7, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("wt_rn_data", bus.ex_rn_data,  64'hDEAD);
        check("wt_asel",    64'(bus.ex_a_sel), 64'd0);
        set_memwb(5'd0, 1'b0, 64'h0);

        // Invalid decode slot clears write/load control
        set_id(1'b0, 5'd0, 5'd0, 5'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check("inv_valid", 64'(bus.ex_valid),     64'd0);
        check("inv_rw",    64'(bus.ex_reg_write), 64'd0);
        check("inv_mr",    64'(bus.ex_mem_read),  64'd0);

        // Flush over a load-use condition
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd8, 5'd0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        check("fl_stall", 64'(bus.stall), 64'd0);
        step();
        check("fl_valid", 64'(bus.ex_valid),     64'd0);
        check("fl_rw",    64'(bus.ex_reg_write), 64'd0);
        bus.flush = 1'b0;

        // Reset in the middle of a stall
        set_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd14, 5'd0, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("rs_stall_pre", 64'(bus.stall), 64'd1);
        reset = 1'b1;
        #1;
        check("rs_stall", 64'(bus.stall), 64'd0);
        step();
        check("rs_valid", 64'(bus.ex_valid),    64'd0);
        check("rs_rd",    64'(bus.ex_rd),       64'd0);
        check("rs_mr",    64'(bus.ex_mem_read), 64'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
